// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling ratio,
// common to the transmitter and the receiver running on the same tick.
package uart_pkg;

  localparam int STATE_W       = 3;
  localparam int TICKS_PER_BIT = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, NB_DATA data bits LSB first, optional even
// parity bit (UART_TX_PARITY_EN), stop period of SB_TICK oversampling ticks.
import uart_pkg::*;

module uart_tx #(
  parameter int NB_DATA     = 8,
  parameter int SB_TICK     = 16,
  parameter int NB_TICK_CNT = 5
) (
  input  logic                i_clk,
  input  logic                reset,
  input  logic                i_tick,
  input  logic                i_tx_start,
  input  logic [NB_DATA-1:0]  i_data,
  output logic                o_tx,
  output logic                o_tx_done,
  output logic                o_busy,
  output logic [STATE_W-1:0]  o_state
);

  // Handshake: i_tx_start is a level request, accepted on any edge where the
  // FSM is idle; o_busy covers acceptance through completion, o_tx_done is a
  // single-cycle pulse in the cycle the FSM is back in idle.

  localparam logic [NB_TICK_CNT-1:0] BIT_LAST  = NB_TICK_CNT'(TICKS_PER_BIT - 1);
  localparam logic [NB_TICK_CNT-1:0] STOP_LAST = NB_TICK_CNT'(SB_TICK - 1);
  localparam logic [3:0]             DATA_LAST = 4'(NB_DATA - 1);

  uart_state_e              state_q, state_d;
  logic [NB_TICK_CNT-1:0]   tick_q, tick_d;
  logic [3:0]               bit_q, bit_d;
  logic [NB_DATA-1:0]       shift_q, shift_d;
  logic                     tx_q, tx_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic                     parity_q, parity_d;
`endif

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        // Tick is deliberately ignored here so the start bit gets a full 16.
        if (i_tx_start) begin
          state_d  = ST_START;
          shift_d  = i_data;
          tick_d   = '0;
          bit_d    = '0;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d = ^i_data;
`endif
        end
      end
      ST_START: begin
        if (i_tick) begin
          if (tick_q == BIT_LAST) begin
            state_d = ST_DATA;
            tick_d  = '0;
            bit_d   = '0;
            tx_d    = shift_q[0];
          end else begin
            tick_d = tick_q + NB_TICK_CNT'(1);
          end
        end
      end
      ST_DATA: begin
        if (i_tick) begin
          if (tick_q == BIT_LAST) begin
            tick_d  = '0;
            shift_d = shift_q >> 1;
            if (bit_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_d = ST_PARITY;
              tx_d    = parity_q;
`else
              state_d = ST_STOP;
              tx_d    = 1'b1;
`endif
            end else begin
              bit_d = bit_q + 4'd1;
              tx_d  = shift_d[0];
            end
          end else begin
            tick_d = tick_q + NB_TICK_CNT'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (i_tick) begin
          if (tick_q == BIT_LAST) begin
            state_d = ST_STOP;
            tick_d  = '0;
            tx_d    = 1'b1;
          end else begin
            tick_d = tick_q + NB_TICK_CNT'(1);
          end
        end
      end
`endif
      ST_STOP: begin
        tx_d = 1'b1;
        if (i_tick) begin
          if (tick_q == STOP_LAST) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            tick_d = tick_q + NB_TICK_CNT'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign o_tx      = tx_q;
  assign o_tx_done = done_q;
  assign o_busy    = busy_q;
  assign o_state   = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: bit-accurate frame checks with the tick every
// cycle and divided by 9, mid-frame request/data changes, back-to-back, reset.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_tick;
  logic       i_tx_start;
  logic [7:0] i_data;
  logic       o_tx;
  logic       o_tx_done;
  logic       o_busy;
  logic [2:0] o_state;

  int n_cmp = 0;
  int n_bad = 0;
  int div   = 1;
  int ph    = 0;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  always #5 clk = ~clk;

  uart_tx dut (
    .i_clk      (clk),
    .reset      (reset),
    .i_tick     (i_tick),
    .i_tx_start (i_tx_start),
    .i_data     (i_data),
    .o_tx       (o_tx),
    .o_tx_done  (o_tx_done),
    .o_busy     (o_busy),
    .o_state    (o_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: tick is high on the edge where the divider phase is 0.
  task automatic step();
    i_tick = (ph == 0);
    @(posedge clk);
    ph = (ph + 1 >= div) ? 0 : ph + 1;
    @(negedge clk);
  endtask

  // Called at the sample just after the accepting edge; returns at the done sample.
  task automatic check_frame(input string tag, input logic [7:0] data,
                             input int bpc, input int poke_k);
    logic [10:0] bits;
    int nb;
    int n;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = data;
    if (PAR) bits[9] = ^data;
    nb = PAR ? 11 : 10;
    n  = nb * bpc;
    for (int k = 0; k < n; k++) begin
      if (k == poke_k) begin
        i_tx_start = 1'b1;
        i_data     = 8'hFF;
      end
      if (k == poke_k + 1) i_tx_start = 1'b0;
      if ((k % bpc == 0) || (k % bpc == bpc - 1)) begin
        chk($sformatf("%s tx k=%0d", tag, k), o_tx, bits[k / bpc]);
        chk($sformatf("%s busy k=%0d", tag, k), o_busy, 1'b1);
        chk($sformatf("%s done k=%0d", tag, k), o_tx_done, 1'b0);
      end
      step();
    end
    chk({tag, " done"}, o_tx_done, 1'b1);
    chk({tag, " busy end"}, o_busy, 1'b0);
    chk({tag, " tx end"}, o_tx, 1'b1);
    chk({tag, " state end"}, o_state, 3'd0);
  endtask

  initial begin
    reset      = 1'b0;
    i_tick     = 1'b0;
    i_tx_start = 1'b0;
    i_data     = 8'h00;
    step();
    step();
    chk("rst tx", o_tx, 1'b1);
    chk("rst busy", o_busy, 1'b0);
    chk("rst done", o_tx_done, 1'b0);
    chk("rst state", o_state, 3'd0);

    reset = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("idle ticks busy", o_busy, 1'b0);
    chk("idle ticks tx", o_tx, 1'b1);

    // A5 with a tick every cycle and a one-cycle request
    i_data = 8'hA5; i_tx_start = 1'b1;
    step();
    i_tx_start = 1'b0;
    check_frame("a5", 8'hA5, 16, -10);
    step();
    chk("a5 done one cycle", o_tx_done, 1'b0);

    // Tick divided by 9, aligned so the accepting edge also carries a tick
    div = 9; ph = 0;
    i_data = 8'h3C; i_tx_start = 1'b1;
    step();
    i_tx_start = 1'b0;
    check_frame("3c div9", 8'h3C, 144, -10);
    div = 1; ph = 0;
    step();

    // Request and data change mid-frame must not affect it or queue a frame
    i_data = 8'h0F; i_tx_start = 1'b1;
    step();
    i_tx_start = 1'b0;
    check_frame("0f poke", 8'h0F, 16, 40);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("0f no second frame", o_busy, 1'b0);
    end

    // Request held high: two frames with only the done cycle between
    i_data = 8'h55; i_tx_start = 1'b1;
    step();
    check_frame("b2b1", 8'h55, 16, -10);
    step();
    check_frame("b2b2", 8'h55, 16, -1);
    step();
    chk("b2b stops", o_busy, 1'b0);
    chk("b2b done one cycle", o_tx_done, 1'b0);

    // Reset in DATA bit 3 (value 0 for F7), then a clean frame
    i_data = 8'hF7; i_tx_start = 1'b1;
    step();
    i_tx_start = 1'b0;
    for (int i = 0; i < 70; i++) step();
    chk("pre-rst tx bit3", o_tx, 1'b0);
    chk("pre-rst state", o_state, 3'd2);
    reset = 1'b0;
    step();
    chk("mid rst tx", o_tx, 1'b1);
    chk("mid rst busy", o_busy, 1'b0);
    chk("mid rst done", o_tx_done, 1'b0);
    chk("mid rst state", o_state, 3'd0);
    reset = 1'b1;
    step();
    i_data = 8'hC3; i_tx_start = 1'b1;
    step();
    i_tx_start = 1'b0;
    check_frame("after rst", 8'hC3, 16, -10);
    step();

    // 07: odd popcount, so parity bit is 1 when parity is built in
    i_data = 8'h07; i_tx_start = 1'b1;
    step();
    i_tx_start = 1'b0;
    check_frame("07", 8'h07, 16, -10);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
